// File: rtl/serial_mult_rr_arbiter.sv
// serial_mult_rr_arbiter: shares one signed serial multiplier between N requester lanes.
// Lanes are granted round-robin; the granted lane's operands are latched, the multiplier
// is started with a one-cycle mul_en pulse, and the 2W-bit product is returned with the
// lane id. A WAIT-state timer reports an error if the multiplier never completes.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_a/req_b      per-lane request and operands (lane i at [i*W +: W])
//   req_ready                  one-hot accept pulse to the granted lane
//   mul_en/mul_a/mul_b         multiplier start pulse and held operands
//   mul_valid/mul_s            multiplier done level and product
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_data/rsp_err    lane id, signed product (0 on error), timeout flag
module serial_mult_rr_arbiter #(
  parameter int unsigned W       = 11,
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_valid,
  input  logic [N*W-1:0]        req_a,
  input  logic [N*W-1:0]        req_b,
  output logic [N-1:0]          req_ready,
  output logic                  mul_en,
  output logic [W-1:0]          mul_a,
  output logic [W-1:0]          mul_b,
  input  logic                  mul_valid,
  input  logic [2*W-1:0]        mul_s,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [$clog2(N)-1:0]  rsp_id,
  output logic [2*W-1:0]        rsp_data,
  output logic                  rsp_err
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned TW  = $clog2(TIMEOUT);
  localparam int unsigned PW  = 2 * W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [IDW-1:0] id_q, id_d;
  logic [PW-1:0]  rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;

  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;
  logic           mul_done;
  logic           timed_out;

  // Only a rising edge of the done level counts, so a stale high level is ignored.
  assign mul_done  = mul_valid & ~valid_q;
  assign timed_out = (timer_q == TW'(TIMEOUT - 1));

  // Round-robin scan: first requesting lane at or after rr_ptr, wrapping at N.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(N)) begin
        scan_sum = scan_sum - (IDW+1)'(N);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (mul_done || timed_out) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs decoded from state; req_ready is also held low while in reset
  // so every output reads 0 during reset regardless of incoming requests.
  always_comb begin
    req_ready = '0;
    mul_en    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:  if (grant_found && rst_n) req_ready = N'(1) << grant_id;
      S_ISSUE: mul_en = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-values: operand latch, timer, response capture, pointer advance.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    timer_d    = timer_q;
    valid_d    = mul_valid;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          op_a_d = req_a[32'(grant_id) * W +: W];
          op_b_d = req_b[32'(grant_id) * W +: W];
          id_d   = grant_id;
        end
      end
      S_ISSUE: timer_d = '0;
      S_WAIT: begin
        if (mul_done) begin
          rsp_data_d = mul_s;
          rsp_err_d  = 1'b0;
        end else if (timed_out) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (id_q == IDW'(N - 1)) ? '0 : IDW'(id_q + IDW'(1));
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      timer_q    <= '0;
      valid_q    <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      timer_q    <= timer_d;
      valid_q    <= valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign mul_a    = op_a_q;
  assign mul_b    = op_b_q;
  assign rsp_id   = id_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_serial_mult_rr_arbiter.sv
// Testbench for serial_mult_rr_arbiter: a transaction-level model tracks the expected
// grant, operands, response timing and product every cycle; directed tests add literal
// expectations for the scenarios of interest.
`timescale 1ns/1ps
module tb_serial_mult_rr_arbiter;

  localparam int W       = 11;
  localparam int N       = 4;
  localparam int TIMEOUT = 64;
  localparam int PW      = 2 * W;
  localparam int IDW     = $clog2(N);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*W-1:0]    req_a, req_b;
  logic [N-1:0]      req_ready;
  logic              mul_en;
  logic [W-1:0]      mul_a, mul_b;
  logic              mul_valid;
  logic [PW-1:0]     mul_s;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [PW-1:0]     rsp_data;
  logic              rsp_err;

  serial_mult_rr_arbiter #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid(mul_valid), .mul_s(mul_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    return PW'(int'($signed(a)) * int'($signed(b)));
  endfunction

  // Multiplier stub: mode 0 = done level visible stub_lat cycles after the issue
  // cycle, mode 1 = hung (never done), mode 2 = done level/product driven by the bench.
  int            stub_mode = 0;
  int            stub_lat  = 3;
  int            st_cnt    = 0;
  logic          st_valid  = 1'b0;
  logic [PW-1:0] st_s      = '0;
  logic          man_valid = 1'b0;
  logic [PW-1:0] man_s     = '0;

  always @(posedge clk) begin
    if (mul_en) begin
      st_s     <= prod(mul_a, mul_b);
      st_valid <= (stub_mode == 0 && stub_lat == 1);
      st_cnt   <= (stub_mode == 0) ? stub_lat - 1 : 0;
    end else if (st_cnt != 0) begin
      st_cnt <= st_cnt - 1;
      if (st_cnt == 1) st_valid <= 1'b1;
    end
  end

  assign mul_valid = (stub_mode == 2) ? man_valid : st_valid;
  assign mul_s     = (stub_mode == 2) ? man_s     : st_s;

  // Transaction-level model and per-cycle compare.
  bit            m_busy = 0;
  bit            m_have = 0;
  int            m_ptr  = 0;
  int            m_g, m_id, m_start;
  logic [W-1:0]  m_a, m_b;
  logic [PW-1:0] m_data;
  logic          m_err;
  logic [N-1:0]  last_grant = '0;
  int            mul_en_cnt = 0;
  int            grant_log[$];
  logic [PW-1:0] rsp_by_lane[N];

  always @(negedge clk) begin
    logic [N-1:0] exp_rr;
    int           lane;
    if (!rst_n) begin
      m_busy     = 0;
      m_have     = 0;
      m_ptr      = 0;
      last_grant = '0;
    end else begin
      exp_rr = '0;
      lane   = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          int l;
          l = (m_ptr + k) % N;
          if (lane < 0 && req_valid[l]) lane = l;
        end
      end
      if (lane >= 0) exp_rr[lane] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rr));
      last_grant = req_ready;
      if (lane >= 0) begin
        m_busy = 1;
        m_have = 1;
        m_g    = cyc;
        m_id   = lane;
        m_a    = req_a[lane*W +: W];
        m_b    = req_b[lane*W +: W];
        grant_log.push_back(lane);
        if (stub_mode == 1) begin
          m_data  = '0;
          m_err   = 1'b1;
          m_start = cyc + 2 + TIMEOUT;
        end else begin
          m_data  = prod(m_a, m_b);
          m_err   = 1'b0;
          m_start = (stub_mode == 0) ? cyc + 2 + stub_lat : -1;
        end
      end
      chk("mul_en", 64'(mul_en), 64'(m_busy && cyc == m_g + 1));
      if (mul_en) mul_en_cnt++;
      if (m_have && cyc > m_g) begin
        chk("mul_a", 64'(mul_a), 64'(m_a));
        chk("mul_b", 64'(mul_b), 64'(m_b));
      end
      if (!m_busy) chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
      else if (m_start >= 0) chk("rsp_valid_timing", 64'(rsp_valid), 64'(cyc >= m_start));
      if (m_busy && rsp_valid) begin
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_data", 64'(rsp_data), 64'(m_data));
        chk("rsp_err", 64'(rsp_err), 64'(m_err));
        if (rsp_ready) begin
          rsp_by_lane[m_id] = rsp_data;
          m_busy = 0;
          m_ptr  = (m_id + 1) % N;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input int a, input int b);
    req_a[lane*W +: W] = W'(a);
    req_b[lane*W +: W] = W'(b);
  endtask

  // Wait for the lane's grant, then withdraw its request.
  task automatic wait_grant(input int lane);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1);
      if (last_grant[lane]) seen = 1;
    end
    req_valid[lane] = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL grant_wait: lane %0d never granted", lane);
    end
  endtask

  task automatic issue(input int lane, input int a, input int b);
    set_lane(lane, a, b);
    req_valid[lane] = 1'b1;
    wait_grant(lane);
  endtask

  task automatic wait_rsp(output logic [IDW-1:0] id, output logic [PW-1:0] data,
                          output logic err);
    bit seen;
    seen = 0;
    id = '0; data = '0; err = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step(1);
      if (rsp_valid) begin
        seen = 1;
        id   = rsp_id;
        data = rsp_data;
        err  = rsp_err;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: no response within budget");
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_mul_en"},    64'(mul_en),    64'd0);
    chk({tag, "_mul_a"},     64'(mul_a),     64'd0);
    chk({tag, "_mul_b"},     64'(mul_b),     64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_id"},    64'(rsp_id),    64'd0);
    chk({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
    chk({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(3);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IDW-1:0] id;
    logic [PW-1:0]  data;
    logic           err;
    int             en0, gl0, rv_seen;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    do_reset();
    rsp_ready = 1'b1;

    // 1: single request on lane 2
    stub_mode = 0;
    stub_lat  = 3;
    en0 = mul_en_cnt;
    gl0 = grant_log.size();
    issue(2, -5, 7);
    wait_rsp(id, data, err);
    chk("t1_id", 64'(id), 64'd2);
    chk("t1_data", 64'(data), 64'(22'h3FFFDD));
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_mul_en_pulses", 64'(mul_en_cnt - en0), 64'd1);
    chk("t1_grants", 64'(grant_log.size() - gl0), 64'd1);
    step(2);

    // 2: all lanes requesting continuously from a fresh pointer
    do_reset();
    grant_log.delete();
    stub_lat = 2;
    set_lane(0, -1024, -1024);
    set_lane(1, 1023, -1024);
    set_lane(2, -1, -1);
    set_lane(3, 37, -19);
    req_valid = 4'hF;
    for (int i = 0; i < 200 && grant_log.size() < 5; i++) step(1);
    req_valid = '0;
    step(12);
    chk("t2_ngrants", 64'(grant_log.size()), 64'd5);
    if (grant_log.size() >= 5) begin
      chk("t2_order0", 64'(grant_log[0]), 64'd0);
      chk("t2_order1", 64'(grant_log[1]), 64'd1);
      chk("t2_order2", 64'(grant_log[2]), 64'd2);
      chk("t2_order3", 64'(grant_log[3]), 64'd3);
      chk("t2_order4", 64'(grant_log[4]), 64'd0);
    end
    chk("t2_lane0", 64'(rsp_by_lane[0]), 64'(22'd1048576));
    chk("t2_lane1", 64'(rsp_by_lane[1]), 64'(22'h300400));
    chk("t2_lane2", 64'(rsp_by_lane[2]), 64'(22'd1));
    chk("t2_lane3", 64'(rsp_by_lane[3]), 64'(22'h3FFD41));

    // 3: hung multiplier -> timeout, then a normal op
    stub_mode = 1;
    issue(1, 100, -3);
    wait_rsp(id, data, err);
    chk("t3_to_id", 64'(id), 64'd1);
    chk("t3_to_err", 64'(err), 64'd1);
    chk("t3_to_data", 64'(data), 64'd0);
    step(1);
    stub_mode = 0;
    stub_lat  = 3;
    issue(1, 100, -3);
    wait_rsp(id, data, err);
    chk("t3_ok_err", 64'(err), 64'd0);
    chk("t3_ok_data", 64'(data), 64'(22'h3FFED4));
    step(1);

    // 4: back-pressure holds the response and blocks new grants
    rsp_ready = 1'b0;
    issue(0, 12, 12);
    wait_rsp(id, data, err);
    en0 = mul_en_cnt;
    gl0 = grant_log.size();
    set_lane(3, 5, 6);
    req_valid[3] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t4_hold_data", 64'(rsp_data), 64'd144);
      chk("t4_hold_id", 64'(rsp_id), 64'd0);
    end
    chk("t4_no_mul_en", 64'(mul_en_cnt - en0), 64'd0);
    chk("t4_no_grant", 64'(grant_log.size() - gl0), 64'd0);
    rsp_ready = 1'b1;
    wait_grant(3);
    wait_rsp(id, data, err);
    chk("t4_next_id", 64'(id), 64'd3);
    chk("t4_next_data", 64'(data), 64'd30);
    step(1);

    // 5: reset during WAIT abandons the op and clears the pointer
    issue(1, 2, 2);
    wait_rsp(id, data, err);
    chk("t5_pre_data", 64'(data), 64'd4);
    step(1);
    stub_lat = 10;
    issue(2, 3, 3);
    step(4);
    chk("t5_in_wait", 64'(rsp_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async");
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (rsp_valid) rv_seen++;
    end
    chk("t5_no_rsp", 64'(rv_seen), 64'd0);
    stub_lat = 3;
    set_lane(0, 4, -4);
    set_lane(3, 9, 9);
    req_valid = 4'b1001;
    step(1);
    chk("t5_ptr_zero_grant", 64'(last_grant), 64'(4'b0001));
    req_valid[0] = 1'b0;
    wait_rsp(id, data, err);
    chk("t5_l0_data", 64'(data), 64'(22'h3FFFF0));
    wait_grant(3);
    wait_rsp(id, data, err);
    chk("t5_l3_id", 64'(id), 64'd3);
    chk("t5_l3_data", 64'(data), 64'd81);
    step(1);

    // 6: done level already high on entry; capture only on its re-rise
    stub_mode = 2;
    man_valid = 1'b1;
    man_s     = 22'h3FFFC1;
    issue(0, -7, 9);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("t6_stuck_high", 64'(rsp_valid), 64'd0);
    end
    man_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t6_low", 64'(rsp_valid), 64'd0);
    end
    man_valid = 1'b1;
    step(1);
    chk("t6_rise_valid", 64'(rsp_valid), 64'd1);
    chk("t6_rise_data", 64'(rsp_data), 64'(22'h3FFFC1));
    chk("t6_rise_err", 64'(rsp_err), 64'd0);
    step(2);
    stub_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
